// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache responder: one line-aligned fetch per cycle,
// a single outstanding refill at a time, and flush/fence_i handling around that refill.
module icache_fetch_responder #(
  parameter int PC_WIDTH = 39,
  parameter int SETS     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_ifu_icache_vld,
  input  logic [PC_WIDTH-1:0] i_ifu_icache_pc_addr,
  input  logic [1:0]          i_ifu_icache_id,
  input  logic                i_ifu_flush,
  input  logic                i_fence_i,
  output logic                o_icache_ifu_vld,
  output logic [1:0]          o_icache_ifu_id,
  output logic [127:0]        o_icache_ifu_data,
  output logic                o_icache_ifu_stall,
  output logic                o_mem_req_vld,
  output logic [PC_WIDTH-1:0] o_mem_req_addr,
  input  logic                i_mem_req_rdy,
  input  logic                i_mem_rsp_vld,
  input  logic [127:0]        i_mem_rsp_data
);

  localparam int IDXW  = $clog2(SETS);
  localparam int LINEW = PC_WIDTH - 4;
  localparam int TAGW  = LINEW - IDXW;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [SETS-1:0]     valid_q, valid_d;
  logic [TAGW-1:0]     tag_q  [SETS];
  logic [127:0]        data_q [SETS];
  logic                s1_vld_q, s1_vld_d;
  logic [LINEW-1:0]    s1_line_q, s1_line_d;
  logic [1:0]          s1_id_q, s1_id_d;
  logic [LINEW-1:0]    mem_line_q, mem_line_d;
  logic                mem_req_vld_q, mem_req_vld_d;
  logic                kill_q, kill_d;
  logic                fence_pend_q, fence_pend_d;
  logic                out_vld_q, out_vld_d;
  logic [1:0]          out_id_q, out_id_d;
  logic [127:0]        out_data_q, out_data_d;

  logic [IDXW-1:0]     s1_idx, fill_idx;
  logic [TAGW-1:0]     s1_tag, fill_tag;
  logic                s1_hit, s1_miss, stall, accept;
  logic                start_refill, finish_refill, fence_req, do_clear;
  logic                unused_pc_lsb;

  assign unused_pc_lsb = ^i_ifu_icache_pc_addr[3:0];

  assign s1_idx   = s1_line_q[IDXW-1:0];
  assign s1_tag   = s1_line_q[LINEW-1:IDXW];
  assign fill_idx = mem_line_q[IDXW-1:0];
  assign fill_tag = mem_line_q[LINEW-1:IDXW];

  assign s1_hit  = s1_vld_q & valid_q[s1_idx] & (tag_q[s1_idx] == s1_tag);
  assign s1_miss = s1_vld_q & ~s1_hit;
  assign stall   = s1_miss | (state_q != S_IDLE);
  assign accept  = i_ifu_icache_vld & ~stall & ~i_ifu_flush;

  assign start_refill  = (state_q == S_IDLE) & s1_miss & ~i_ifu_flush;
  assign finish_refill = (state_q == S_WAIT) & i_mem_rsp_vld;
  // A fence is deferred while a miss is being serviced and lands when the FSM returns to IDLE.
  assign fence_req     = i_fence_i | fence_pend_q;
  assign do_clear      = fence_req & (((state_q == S_IDLE) & ~start_refill) | finish_refill);

  always_comb begin
    state_d       = state_q;
    mem_req_vld_d = mem_req_vld_q;
    mem_line_d    = mem_line_q;
    case (state_q)
      S_IDLE: begin
        if (start_refill) begin
          state_d       = S_REQ;
          mem_req_vld_d = 1'b1;
          mem_line_d    = s1_line_q;
        end
      end
      S_REQ: begin
        if (i_mem_req_rdy) begin
          state_d       = S_WAIT;
          mem_req_vld_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (i_mem_rsp_vld) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    kill_d       = (state_q != S_IDLE) & (kill_q | i_ifu_flush) & ~finish_refill;
    fence_pend_d = fence_req & ~do_clear;

    valid_d = valid_q;
    if (finish_refill) valid_d[fill_idx] = 1'b1;
    if (do_clear) valid_d = '0;

    s1_vld_d  = s1_vld_q;
    s1_line_d = s1_line_q;
    s1_id_d   = s1_id_q;
    if (s1_hit) s1_vld_d = 1'b0;
    if (accept) begin
      s1_vld_d  = 1'b1;
      s1_line_d = i_ifu_icache_pc_addr[PC_WIDTH-1:4];
      s1_id_d   = i_ifu_icache_id;
    end
    if (finish_refill | i_ifu_flush) s1_vld_d = 1'b0;

    out_vld_d  = 1'b0;
    out_id_d   = out_id_q;
    out_data_d = out_data_q;
    if (!i_ifu_flush) begin
      if (s1_hit) begin
        out_vld_d  = 1'b1;
        out_id_d   = s1_id_q;
        out_data_d = data_q[s1_idx];
      end else if (finish_refill & ~kill_q & s1_vld_q) begin
        out_vld_d  = 1'b1;
        out_id_d   = s1_id_q;
        out_data_d = i_mem_rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      s1_vld_q      <= 1'b0;
      s1_line_q     <= '0;
      s1_id_q       <= '0;
      mem_line_q    <= '0;
      mem_req_vld_q <= 1'b0;
      kill_q        <= 1'b0;
      fence_pend_q  <= 1'b0;
      out_vld_q     <= 1'b0;
      out_id_q      <= '0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      s1_vld_q      <= s1_vld_d;
      s1_line_q     <= s1_line_d;
      s1_id_q       <= s1_id_d;
      mem_line_q    <= mem_line_d;
      mem_req_vld_q <= mem_req_vld_d;
      kill_q        <= kill_d;
      fence_pend_q  <= fence_pend_d;
      out_vld_q     <= out_vld_d;
      out_id_q      <= out_id_d;
      out_data_q    <= out_data_d;
    end
  end

  // Line storage needs no reset: valid bits alone decide whether it is trusted.
  always_ff @(posedge clk) begin
    if (finish_refill) begin
      data_q[fill_idx] <= i_mem_rsp_data;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  assign o_icache_ifu_vld   = out_vld_q & ~i_ifu_flush;
  assign o_icache_ifu_id    = out_id_q;
  assign o_icache_ifu_data  = out_data_q;
  assign o_icache_ifu_stall = stall;
  assign o_mem_req_vld      = mem_req_vld_q;
  assign o_mem_req_addr     = {mem_line_q, 4'b0000};

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Scoreboard bench for icache_fetch_responder: the driver predicts each response from
// a set/tag model of the cache and queues it; a negedge monitor pops and compares.
module tb_icache_fetch_responder;

  localparam int PC_WIDTH = 39;
  localparam int SETS     = 16;
  localparam int IDXW     = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                vld = 1'b0;
  logic [PC_WIDTH-1:0] pcIn = '0;
  logic [1:0]          idIn = '0;
  logic                flush = 1'b0;
  logic                fence = 1'b0;
  logic                rdy = 1'b0;
  logic                rspVld = 1'b0;
  logic [127:0]        rspData = '0;
  logic                oVld, oStall, oMemVld;
  logic [1:0]          oId;
  logic [127:0]        oData;
  logic [PC_WIDTH-1:0] oMemAddr;

  icache_fetch_responder #(.PC_WIDTH(PC_WIDTH), .SETS(SETS)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_ifu_icache_vld    (vld),
    .i_ifu_icache_pc_addr(pcIn),
    .i_ifu_icache_id     (idIn),
    .i_ifu_flush         (flush),
    .i_fence_i           (fence),
    .o_icache_ifu_vld    (oVld),
    .o_icache_ifu_id     (oId),
    .o_icache_ifu_data   (oData),
    .o_icache_ifu_stall  (oStall),
    .o_mem_req_vld       (oMemVld),
    .o_mem_req_addr      (oMemAddr),
    .i_mem_req_rdy       (rdy),
    .i_mem_rsp_vld       (rspVld),
    .i_mem_rsp_data      (rspData)
  );

  typedef struct {
    logic [1:0]   id;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t              expQ[$];
  exp_t              monE;
  int                testsRun = 0;
  int                testsFailed = 0;
  int                cyc = 0;
  bit                monOn = 1'b0;
  bit                mvalid[SETS];
  longint unsigned   mtag[SETS];
  logic [127:0]      mdata[SETS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: expired expectations are missing responses; any response must match the queue head.
  always @(negedge clk) begin
    if (monOn) begin
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        monE = expQ.pop_front();
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL missing_resp: got none expected id %0d at cycle %0d", monE.id, monE.cyc);
      end
      if (oVld) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_resp: got id %0d data %0h expected none (cycle %0d)", oId, oData, cyc);
        end else begin
          monE = expQ.pop_front();
          checkOutput("resp_id", 128'(oId), 128'(monE.id));
          checkOutput("resp_data", oData, monE.data);
          checkOutput("resp_cycle", 128'(cyc), 128'(monE.cyc));
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
    vld = 1'b0; flush = 1'b0; fence = 1'b0; rdy = 1'b0; rspVld = 1'b0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [PC_WIDTH-1:0] randPc();
    longint unsigned v;
    v = (longint'($urandom_range(0, 2)) << (4 + IDXW)) | (longint'($urandom_range(0, 3)) << 4)
        | longint'($urandom_range(0, 15));
    return PC_WIDTH'(v);
  endfunction

  function automatic bit modelHit(input logic [PC_WIDTH-1:0] pc);
    longint unsigned line = longint'(pc) >> 4;
    return mvalid[line % SETS] && (mtag[line % SETS] == line / SETS);
  endfunction

  task automatic waitNoStall();
    int n = 0;
    while (oStall && n < 40) begin
      nextCycle();
      n++;
    end
    if (oStall) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL stall_timeout: got stall 1 expected 0 within 40 cycles");
    end
  endtask

  // flushMode: 0 none, 1 in REQ, 2 in WAIT, 3 in the response cycle.
  // fenceMode: 0 none, 1 while the miss sits in S1, 2 in REQ, 3 in WAIT.
  task automatic serviceMiss(input logic [PC_WIDTH-1:0] pc, input logic [1:0] id,
                             input int flushMode, input int fenceMode,
                             input int rdyDelay, input int rspDelay);
    longint unsigned     line = longint'(pc) >> 4;
    logic [PC_WIDTH-1:0] expAddr = PC_WIDTH'(line << 4);
    bit                  killed = 0;
    bit                  fenced = 0;
    int                  n = 0;
    exp_t                e;
    logic [127:0]        d;
    nextCycle();
    checkOutput("stall_on_miss", 128'(oStall), 128'(1));
    if (fenceMode == 1) begin fence = 1'b1; fenced = 1; end
    do begin
      nextCycle();
      n++;
    end while (!oMemVld && n < 4);
    if (!oMemVld) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL memreq_timeout: got no request expected addr %0h", expAddr);
      return;
    end
    checkOutput("memreq_addr", 128'(oMemAddr), 128'(expAddr));
    for (int i = 0; i < rdyDelay; i++) begin
      checkOutput("memreq_hold_vld", 128'(oMemVld), 128'(1));
      checkOutput("memreq_hold_addr", 128'(oMemAddr), 128'(expAddr));
      checkOutput("stall_in_req", 128'(oStall), 128'(1));
      vld = 1'b1;
      pcIn = randPc();
      if (flushMode == 1 && i == 0) begin flush = 1'b1; killed = 1; end
      if (fenceMode == 2 && i == 0) begin fence = 1'b1; fenced = 1; end
      nextCycle();
    end
    checkOutput("memreq_at_rdy", 128'(oMemVld), 128'(1));
    rdy = 1'b1;
    nextCycle();
    for (int j = 0; j < rspDelay; j++) begin
      checkOutput("stall_in_wait", 128'(oStall), 128'(1));
      if (flushMode == 2 && j == 0) begin flush = 1'b1; killed = 1; end
      if (fenceMode == 3 && j == 0) begin fence = 1'b1; fenced = 1; end
      nextCycle();
    end
    checkOutput("memreq_dropped", 128'(oMemVld), 128'(0));
    d = rand128();
    rspVld = 1'b1;
    rspData = d;
    if (flushMode == 3) begin flush = 1'b1; killed = 1; end
    mdata[line % SETS] = d;
    mtag[line % SETS] = line / SETS;
    if (fenced) begin
      for (int s = 0; s < SETS; s++) mvalid[s] = 0;
    end else begin
      mvalid[line % SETS] = 1;
    end
    if (!killed) begin
      e.id = id; e.data = d; e.cyc = cyc + 1;
      expQ.push_back(e);
    end
    nextCycle();
    checkOutput("stall_after_refill", 128'(oStall), 128'(0));
  endtask

  // Issues one fetch in the current cycle; returns positioned at a cycle free for new stimulus.
  task automatic applyStimulus(input logic [PC_WIDTH-1:0] pc, input logic [1:0] id,
                               input int flushMode, input int fenceMode,
                               input int rdyDelay, input int rspDelay);
    exp_t            e;
    longint unsigned line = longint'(pc) >> 4;
    waitNoStall();
    vld = 1'b1;
    pcIn = pc;
    idIn = id;
    checkOutput("no_memreq_on_issue", 128'(oMemVld), 128'(0));
    if (modelHit(pc)) begin
      e.id = id; e.data = mdata[line % SETS]; e.cyc = cyc + 2;
      expQ.push_back(e);
      nextCycle();
    end else begin
      serviceMiss(pc, id, flushMode, fenceMode, rdyDelay, rspDelay);
    end
  endtask

  initial begin
    int r, fm, fe, rd, rs, burst;
    for (int s = 0; s < SETS; s++) begin mvalid[s] = 0; mtag[s] = 0; mdata[s] = '0; end
    #12;
    checkOutput("reset_vld", 128'(oVld), 128'(0));
    checkOutput("reset_id", 128'(oId), 128'(0));
    checkOutput("reset_data", oData, 128'(0));
    checkOutput("reset_stall", 128'(oStall), 128'(0));
    checkOutput("reset_memreq_vld", 128'(oMemVld), 128'(0));
    checkOutput("reset_memreq_addr", 128'(oMemAddr), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    monOn = 1'b1;

    applyStimulus(39'h100, 2'd1, 0, 0, 1, 1);
    applyStimulus(39'h100, 2'd2, 0, 0, 0, 0);
    applyStimulus(39'h104, 2'd3, 0, 0, 0, 0);
    nextCycle();
    nextCycle();

    // A response due in a flush cycle must be swallowed.
    waitNoStall();
    vld = 1'b1; pcIn = 39'h100; idIn = 2'd0;
    nextCycle();
    nextCycle();
    flush = 1'b1;
    #1;
    checkOutput("vld_gated_by_flush", 128'(oVld), 128'(0));
    nextCycle();

    applyStimulus(39'h200, 2'd0, 0, 0, 5, 1);
    applyStimulus(39'h300, 2'd1, 2, 0, 1, 2);
    applyStimulus(39'h300, 2'd2, 0, 0, 0, 0);
    applyStimulus(39'h400, 2'd3, 0, 3, 1, 2);
    applyStimulus(39'h100, 2'd0, 0, 0, 0, 1);
    applyStimulus(39'h400, 2'd1, 0, 0, 2, 0);
    applyStimulus(39'h000, 2'd2, 0, 0, 1, 1);
    applyStimulus(39'h100, 2'd3, 0, 0, 1, 1);
    applyStimulus(39'h000, 2'd0, 0, 0, 0, 0);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        burst = $urandom_range(1, 4);
        for (int b = 0; b < burst; b++) begin
          fm = ($urandom_range(0, 99) < 75) ? 0 : $urandom_range(1, 3);
          fe = ($urandom_range(0, 99) < 80) ? 0 : $urandom_range(1, 3);
          rd = $urandom_range(0, 3);
          rs = $urandom_range(0, 3);
          if ((fm == 1 || fe == 2) && rd == 0) rd = 1;
          if ((fm == 2 || fe == 3) && rs == 0) rs = 1;
          applyStimulus(randPc(), 2'($urandom_range(0, 3)), fm, fe, rd, rs);
        end
      end else if (r < 65) begin
        fence = 1'b1;
        for (int s = 0; s < SETS; s++) mvalid[s] = 0;
        nextCycle();
      end else if (r < 75) begin
        nextCycle();
        nextCycle();
        vld = 1'b1; pcIn = randPc(); flush = 1'b1;
        nextCycle();
      end else if (r < 85) begin
        rspVld = 1'b1; rspData = rand128(); rdy = 1'b1;
        nextCycle();
      end else begin
        nextCycle();
      end
    end

    for (int k = 0; k < 6; k++) nextCycle();
    checkOutput("queue_drained", 128'(expQ.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
